// File: rtl/crawl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : crawl_sequencer
//  Description : Run/pause/single-step controller for the crawling 4-digit
//                message display. A prescaler on the board clock produces
//                step enables at a slow or fast rate. Each step moves a
//                circular read position through a packed nibble message. The
//                4-nibble window at that position goes to the display mux.
//  Option      : CRAWL_PAUSE_AT_WRAP_EN - when defined, a RUN step that wraps
//                the position also drops the sequencer into PAUSE, so the
//                message plays through once and stops.
//  Revision    : 1.0 - initial single-clock-domain release
// ============================================================================
module crawl_sequencer #(
    parameter int SLOW_DIV = 50_000_000,   // cycles per step, normal rate
    parameter int FAST_DIV = 12_500_000,   // cycles per step, fast rate (2..SLOW_DIV)
    parameter int MSG_LEN  = 8             // message length in nibbles (>= 4)
) (
    input  logic                         CLK,
    input  logic                         CLEAR,
    input  logic                         ON_OFF,
    input  logic                         SW0,
    input  logic                         SW1,
    input  logic                         SW2,
    input  logic [4*MSG_LEN-1:0]         MSG,
    output logic [15:0]                  WINDOW,
    output logic [$clog2(MSG_LEN)-1:0]   POS,
    output logic                         RUNNING,
    output logic                         STEP_PULSE
);

    localparam int PW = $clog2(MSG_LEN);
    localparam int CW = $clog2(SLOW_DIV);

    localparam logic [CW-1:0] SLOW_TC  = CW'(SLOW_DIV - 1);
    localparam logic [CW-1:0] FAST_TC  = CW'(FAST_DIV - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(MSG_LEN - 1);
    localparam logic [PW:0]   LEN_EXT  = (PW+1)'(MSG_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic            running_q, running_d;
    logic            step_pulse_q, step_pulse_d;

    // Bit 0 is the first synchronizer stage; the button chains carry a third
    // flop so a rising edge of the synchronized level can be detected.
    logic [2:0]      on_off_sync_q, on_off_sync_d;
    logic [2:0]      sw2_sync_q, sw2_sync_d;
    logic [1:0]      sw0_sync_q, sw0_sync_d;
    logic [1:0]      sw1_sync_q, sw1_sync_d;

    logic            w_on_off_rise;
    logic            w_sw2_rise;
    logic            w_sw0_change;
    logic            w_fast;
    logic            w_backward;
    logic            w_tc;
    logic            w_step_run;
    logic            w_step_single;
    logic            w_step;
    logic            w_wrap;
    logic [PW-1:0]   w_pos_next;

    // Synchronized views of the panel inputs.
    assign w_on_off_rise = on_off_sync_q[1] & ~on_off_sync_q[2];
    assign w_sw2_rise    = sw2_sync_q[1]    & ~sw2_sync_q[2];
    // The speed change is seen one cycle early (stage 0 vs stage 1) so the
    // prescaler clears on the very edge the synchronized speed flips.
    assign w_sw0_change  = sw0_sync_q[0] ^ sw0_sync_q[1];
    assign w_fast        = sw0_sync_q[1];
    assign w_backward    = sw1_sync_q[1];

    // Shift the asynchronous panel inputs into their synchronizer chains.
    always_comb begin
        on_off_sync_d = {on_off_sync_q[1:0], ON_OFF};
        sw2_sync_d    = {sw2_sync_q[1:0], SW2};
        sw0_sync_d    = {sw0_sync_q[0], SW0};
        sw1_sync_d    = {sw1_sync_q[0], SW1};
    end

    // Next position and wrap detection for a step in the selected direction.
    always_comb begin
        w_pos_next = pos_q;
        w_wrap     = 1'b0;
        if (w_backward) begin
            w_wrap     = (pos_q == '0);
            w_pos_next = w_wrap ? POS_LAST : pos_q - PW'(1);
        end else begin
            w_wrap     = (pos_q == POS_LAST);
            w_pos_next = w_wrap ? '0 : pos_q + PW'(1);
        end
    end

    // State machine, prescaler and step generation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        pos_d         = pos_q;
        w_step_run    = 1'b0;
        w_step_single = 1'b0;
        w_tc          = (cnt_q == (w_fast ? FAST_TC : SLOW_TC));

        case (state_q)
            ST_IDLE, ST_PAUSE: begin
                // A start press wins over a simultaneous single-step press.
                if (w_on_off_rise) begin
                    state_d = ST_RUN;
                end else if (w_sw2_rise) begin
                    w_step_single = 1'b1;
                end
            end
            ST_RUN: begin
                // A speed change restarts the count and suppresses the step.
                if (!w_sw0_change && w_tc) begin
                    w_step_run = 1'b1;
                end
                if (w_on_off_rise) begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef CRAWL_PAUSE_AT_WRAP_EN
        // Play the message once: a wrapping RUN step parks the sequencer.
        if (w_step_run && w_wrap) begin
            state_d = ST_PAUSE;
        end
`endif

        w_step = w_step_run | w_step_single;
        if (w_step) begin
            pos_d = w_pos_next;
        end

        // Counter only advances while staying in RUN; it is zero otherwise,
        // which also makes it zero on the RUN entry edge.
        if ((state_q == ST_RUN) && (state_d == ST_RUN) && !w_sw0_change && !w_tc) begin
            cnt_d = cnt_q + CW'(1);
        end

        step_pulse_d = w_step;
        running_d    = (state_d == ST_RUN);
    end

    // All state registers, cleared asynchronously by CLEAR.
    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            pos_q         <= '0;
            running_q     <= 1'b0;
            step_pulse_q  <= 1'b0;
            on_off_sync_q <= '0;
            sw2_sync_q    <= '0;
            sw0_sync_q    <= '0;
            sw1_sync_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pos_q         <= pos_d;
            running_q     <= running_d;
            step_pulse_q  <= step_pulse_d;
            on_off_sync_q <= on_off_sync_d;
            sw2_sync_q    <= sw2_sync_d;
            sw0_sync_q    <= sw0_sync_d;
            sw1_sync_q    <= sw1_sync_d;
        end
    end

    // Window slot k shows nibble (POS+k) mod MSG_LEN; slot 0 is the top digit.
    // MSG_LEN >= 4 means a single conditional subtract covers the modulo.
    for (genvar k = 0; k < 4; k++) begin : g_window
        logic [PW:0]   idx_sum;
        logic [PW-1:0] idx;
        assign idx_sum = {1'b0, pos_q} + (PW+1)'(k);
        assign idx     = (idx_sum >= LEN_EXT) ? PW'(idx_sum - LEN_EXT) : idx_sum[PW-1:0];
        assign WINDOW[15-4*k -: 4] = MSG[4*idx +: 4];
    end

    assign POS        = pos_q;
    assign RUNNING    = running_q;
    assign STEP_PULSE = step_pulse_q;

endmodule
`default_nettype wire

// File: doc/crawl_sequencer.md
# crawl_sequencer

Run/pause/step controller for the crawling 4-digit message display. Runs directly on the board clock and uses a prescaler to generate single-cycle step enables at a slow or fast crawl rate. Steps a circular read position through a packed nibble message and presents the current 4-nibble window to the display multiplexer. Replaces the gated-clock start/stop and clock-select path with one clock domain and an explicit state machine.

## Interface
- `SLOW_DIV`, default 50_000_000: clock cycles per step at the normal rate (1 Hz at 50 MHz).
- `FAST_DIV`, default 12_500_000: clock cycles per step at the fast rate (4 Hz); must satisfy 2 ≤ FAST_DIV ≤ SLOW_DIV.
- `MSG_LEN`, default 8: message length in nibbles; must be ≥ 4.
- `CLK`  in  1  board clock, 50 MHz; all state changes on its rising edge.
- `CLEAR`  in  1  asynchronous active-high reset.
- `ON_OFF`  in  1  start/stop button, asynchronous level, active-high.
- `SW0`  in  1  speed select: 0 = SLOW_DIV, 1 = FAST_DIV.
- `SW1`  in  1  direction: 0 = forward (pos+1), 1 = backward (pos−1).
- `SW2`  in  1  single-step request, asynchronous level, active-high.
- `MSG`  in  4*MSG_LEN  packed message; nibble k = MSG[4k+3:4k]; treated as static.
- `WINDOW`  out  16  current display window.
- `POS`  out  $clog2(MSG_LEN)  current read position.
- `RUNNING`  out  1  high while in RUN.
- `STEP_PULSE`  out  1  one-cycle strobe for each position change.

## Operation
- Input synchronizers:
  - ON_OFF and SW2 each pass through a 2-flop synchronizer followed by a rising-edge detector (compares against a third flop).
  - Only rising edges act; held levels are ignored.
  - SW0 and SW1 pass through 2-flop synchronizers and are used as levels.
- States:
  - IDLE (reset state).
  - RUN.
  - PAUSE.
- Transitions:
  - IDLE —ON_OFF edge→ RUN.
  - RUN —ON_OFF edge→ PAUSE.
  - PAUSE —ON_OFF edge→ RUN.
  - IDLE and PAUSE stay put on a SW2 edge, but perform one step.
- Prescaler:
  - A counter runs only in RUN; it holds at 0 in IDLE and PAUSE, and resets to 0 on entering RUN.
  - Terminal count is DIV−1, where DIV is selected by the synchronized SW0.
  - At terminal count: counter → 0 and one step is taken.
  - Any change of synchronized SW0: counter → 0 on that edge with no step, so the first step at the new rate comes a full new DIV later.
- Step:
  - Forward: POS ← (POS+1) mod MSG_LEN.
  - Backward: POS ← (POS+MSG_LEN−1) mod MSG_LEN.
  - STEP_PULSE is high for exactly the cycle after the updating edge.
- Window (combinational from POS and MSG):
  - WINDOW[15:12] = nibble[POS]
  - WINDOW[11:8] = nibble[(POS+1) mod MSG_LEN]
  - WINDOW[7:4] = nibble[(POS+2) mod MSG_LEN]
  - WINDOW[3:0] = nibble[(POS+3) mod MSG_LEN]
- Wrap event: a forward step from MSG_LEN−1 to 0, or a backward step from 0 to MSG_LEN−1.
- Simultaneous events:
  - RUN terminal count coinciding with an ON_OFF edge: the step is taken and the state goes to PAUSE on the same edge.
  - A SW2 edge while in RUN is ignored.
  - A SW2 edge coinciding with an ON_OFF edge in PAUSE: the state goes to RUN and no single step is taken.
- Reset:
  - CLEAR asserted at any time forces, asynchronously: state = IDLE, POS = 0, prescaler = 0, STEP_PULSE = 0, RUNNING = 0, all synchronizer and edge flops = 0.
  - WINDOW then shows nibbles 0..3.

## Timing
- Button latency: a button edge acts on the 3rd rising CLK edge after the input goes high, provided the input is stable across the first edge.
  - ON_OFF: RUNNING changes on that edge.
  - SW2: POS changes on that edge.
- Step period in RUN: exactly DIV cycles between successive STEP_PULSE assertions.
- First step after entering RUN occurs DIV cycles after the entry edge.
- WINDOW is valid in the same cycle as the new POS (zero additional latency); it is a combinational path only from POS/MSG.
- RUNNING and STEP_PULSE are registered outputs.

## Configuration
- `CRAWL_PAUSE_AT_WRAP_EN`
  - Defined: a step in RUN that causes a wrap event also moves RUN → PAUSE on the same edge, so the message plays once and stops with POS at the wrapped value. Single steps in PAUSE/IDLE are unaffected.
  - Undefined: RUN crawls continuously through wrap events.

## Test plan
Bench parameters: SLOW_DIV=8, FAST_DIV=2, MSG_LEN=8, MSG=32'h7654_3210.

- Reset then idle for 50 cycles → POS=0, WINDOW=16'h0123, RUNNING=0, no STEP_PULSE.
- ON_OFF pulse, SW0=0, SW1=0 →
  - RUNNING=1 on the 3rd edge after the pulse.
  - STEP_PULSE every 8 cycles.
  - Successive WINDOW values 16'h1234, 16'h2345.
  - After 8 steps: POS=0 (undefined macro) or RUNNING=0 with POS=0 (macro defined).
- In RUN, set SW1=1 at POS=0 → next step gives POS=7, WINDOW=16'h7012; with macro defined, RUNNING=0 after that step.
- In RUN, toggle SW0 to 1 mid-count → no step for 2 cycles after the synchronized change, then STEP_PULSE every 2 cycles.
- Second ON_OFF pulse → PAUSE, POS frozen. Then a SW2 pulse → exactly one step. A SW2 pulse while RUNNING=1 → no extra step.
- Assert CLEAR mid-RUN between clock edges → all outputs at reset values immediately. After release, a SW2 pulse steps from POS=0.
